// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and the
// multi-cycle divider.
//   start     one-cycle divide request
//   rd1/rd2   dividend / divisor
//   div_ctrl  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   flush     synchronous abort from the hazard unit
//   busy      divider is iterating
//   valid     one-cycle pulse, result is valid
//   result    registered quotient or remainder
interface div_unit_if #(
  parameter int D_WIDTH = 32
);
  logic               start;
  logic [D_WIDTH-1:0] rd1;
  logic [D_WIDTH-1:0] rd2;
  logic [1:0]         div_ctrl;
  logic               flush;
  logic               busy;
  logic               valid;
  logic [D_WIDTH-1:0] result;

  modport master (
    output start, rd1, rd2, div_ctrl, flush,
    input  busy, valid, result
  );

  modport slave (
    input  start, rd1, rd2, div_ctrl, flush,
    output busy, valid, result
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for RV32M
// DIV/DIVU/REM/REMU.  One quotient bit per cycle, D_WIDTH iterations.
// Divide-by-zero and signed overflow bypass the iterations and complete
// on the accepting edge.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    div_unit_if slave: start/rd1/rd2/div_ctrl/flush in,
//          busy/valid/result out
module div_unit #(
  parameter int D_WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);

  localparam int CW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [D_WIDTH-1:0] INT_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]      LAST_CNT = CW'(D_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [D_WIDTH-1:0] quo_q, quo_d;
  logic [D_WIDTH-1:0] rem_q, rem_d;
  logic [D_WIDTH-1:0] dvs_q, dvs_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [D_WIDTH-1:0] result_q, result_d;

  // Accept-edge decode
  logic               accept;
  logic               is_signed;
  logic               div_zero;
  logic               overflow;
  logic [D_WIDTH-1:0] abs_a;
  logic [D_WIDTH-1:0] abs_b;
  logic [D_WIDTH-1:0] fast_res;

  // One restoring iteration
  logic [D_WIDTH:0]   rem_sh;
  logic [D_WIDTH:0]   diff;
  logic               no_borrow;
  logic [D_WIDTH-1:0] rem_nx;
  logic [D_WIDTH-1:0] quo_nx;
  logic [D_WIDTH-1:0] quo_fix;
  logic [D_WIDTH-1:0] rem_fix;

  always_comb begin
    accept    = bus.start && (state_q != CALC) && !bus.flush;
    is_signed = !bus.div_ctrl[0];
    div_zero  = (bus.rd2 == '0);
    overflow  = is_signed && (bus.rd1 == INT_MIN) && (bus.rd2 == '1);
    abs_a     = (is_signed && bus.rd1[D_WIDTH-1]) ? -bus.rd1 : bus.rd1;
    abs_b     = (is_signed && bus.rd2[D_WIDTH-1]) ? -bus.rd2 : bus.rd2;
    if (div_zero) begin
      fast_res = bus.div_ctrl[1] ? bus.rd1 : '1;
    end else begin
      fast_res = bus.div_ctrl[1] ? '0 : bus.rd1;
    end

    // rem < divisor always holds, so the shifted remainder minus the divisor
    // fits in D_WIDTH+1 bits and its top bit is the borrow.
    rem_sh    = {rem_q, quo_q[D_WIDTH-1]};
    diff      = rem_sh - {1'b0, dvs_q};
    no_borrow = !diff[D_WIDTH];
    rem_nx    = no_borrow ? diff[D_WIDTH-1:0] : rem_sh[D_WIDTH-1:0];
    quo_nx    = {quo_q[D_WIDTH-2:0], no_borrow};
    quo_fix   = qneg_q ? -quo_nx : quo_nx;
    rem_fix   = rneg_q ? -rem_nx : rem_nx;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    ctrl_d   = ctrl_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    if (accept) begin
      // Shared by IDLE and DONE so a back-to-back request skips IDLE.
      ctrl_d  = bus.div_ctrl;
      count_d = '0;
      quo_d   = abs_a;
      rem_d   = '0;
      dvs_d   = abs_b;
      qneg_d  = is_signed && (bus.rd1[D_WIDTH-1] ^ bus.rd2[D_WIDTH-1]);
      rneg_d  = is_signed && bus.rd1[D_WIDTH-1];
      if (div_zero || overflow) begin
        state_d  = DONE;
        result_d = fast_res;
      end else begin
        state_d = CALC;
      end
    end

    unique case (state_q)
      IDLE: ;
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          quo_d   = quo_nx;
          rem_d   = rem_nx;
          count_d = count_q + 1'b1;
          if (count_q == LAST_CNT) begin
            state_d  = DONE;
            result_d = ctrl_q[1] ? rem_fix : quo_fix;
          end
        end
      end
      DONE: begin
        if (!accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      ctrl_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      ctrl_q   <= ctrl_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == CALC);
  assign bus.valid  = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with a scoreboard queue.
// The driver pushes expected result/latency on each accepted request; the
// monitor pops and compares whenever valid is seen.
module tb_div_unit;

  logic clk;
  logic rst_n;

  div_unit_if #(.D_WIDTH(32)) bus ();

  div_unit #(.D_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int unsigned acc;
    int unsigned lat;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc;
  int unsigned checks;
  int unsigned failures;
  int unsigned busy_run;
  logic [31:0] last_exp;

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    busy_run = 0;
    last_exp = '0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      chk("busy_valid_exclusive", {31'd0, bus.busy & bus.valid}, 32'd0);
      if (bus.valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=valid result=0x%08h expected=no valid", bus.result);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_result"}, bus.result, e.res);
          chk({e.name, "_latency"}, cyc - e.acc, e.lat);
          chk({e.name, "_busy_cycles"}, busy_run, e.lat);
          last_exp = e.res;
        end
        busy_run = 0;
      end else if (bus.busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  // Drive a request at a negedge; the following posedge accepts it.
  task automatic issue(input string nm, input logic [1:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e,
                       input int unsigned lat, input bit push, input int unsigned hold);
    exp_t x;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.div_ctrl = c;
    bus.rd1      = a;
    bus.rd2      = b;
    @(posedge clk);
    #1;
    if (push) begin
      x.res  = e;
      x.acc  = cyc;
      x.lat  = lat;
      x.name = nm;
      exp_q.push_back(x);
    end
    if (hold > 0) repeat (hold) @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending expected=0 pending", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    int unsigned n;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.rd1      = '0;
    bus.rd2      = '0;
    bus.div_ctrl = 2'b00;

    #3;
    chk("reset_busy",   {31'd0, bus.busy},  32'd0);
    chk("reset_valid",  {31'd0, bus.valid}, 32'd0);
    chk("reset_result", bus.result,         32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Unsigned normal path
    issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 32, 1, 0);
    drain();
    issue("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32, 1, 0);
    drain();

    // Signed normal path
    issue("div_m7_2",  2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32, 1, 0);
    drain();
    issue("rem_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32, 1, 0);
    drain();
    issue("div_7_m2",  2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, 1, 0);
    drain();
    issue("rem_7_m2",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32, 1, 0);
    drain();
    issue("div_min_2", 2'b00, 32'h8000_0000, 32'd2,         32'hC000_0000, 32, 1, 0);
    drain();

    // Divide by zero fast path
    issue("div_5_0",  2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1, 0);
    drain();
    issue("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1, 0);
    drain();
    issue("rem_5_0",  2'b10, 32'd5, 32'd0, 32'd5,         0, 1, 0);
    drain();
    issue("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5,         0, 1, 0);
    drain();

    // Signed overflow fast path; unsigned form of the same operands iterates
    issue("div_ovf",  2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 0);
    drain();
    issue("rem_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, 1, 0);
    drain();
    issue("divu_big", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32, 1, 0);
    drain();
    issue("remu_big", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32, 1, 0);
    drain();

    // Abort mid-iteration: no valid, result keeps the previous value
    issue("abort", 2'b01, 32'hFFFF_FFFF, 32'd3, 32'd0, 32, 0, 0);
    repeat (10) @(negedge clk);
    chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy_after",  {31'd0, bus.busy},  32'd0);
    chk("abort_valid_after", {31'd0, bus.valid}, 32'd0);
    chk("abort_result_kept", bus.result, last_exp);
    repeat (40) @(negedge clk);
    chk("abort_no_restart", {31'd0, bus.busy | bus.valid}, 32'd0);

    // Back-to-back: second request accepted in DONE of the first
    issue("b2b_first", 2'b01, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32, 1, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.valid && n < 100);
    chk("b2b_valid_seen", {31'd0, bus.valid}, 32'd1);
    bus.start    = 1'b1;
    bus.div_ctrl = 2'b11;
    bus.rd1      = 32'd1000;
    bus.rd2      = 32'd9;
    @(posedge clk);
    #1;
    x.res  = 32'd1;
    x.acc  = cyc;
    x.lat  = 32;
    x.name = "b2b_second";
    exp_q.push_back(x);
    bus.start = 1'b0;
    chk("b2b_busy_immediate", {31'd0, bus.busy}, 32'd1);
    drain();

    // start held high during CALC is ignored: exactly one valid
    issue("start_held", 2'b01, 32'd1000, 32'd9, 32'd111, 32, 1, 20);
    drain();
    repeat (10) @(negedge clk);

    // Asynchronous reset between edges mid-CALC
    issue("reset_mid", 2'b01, 32'd1000, 32'd9, 32'd0, 32, 0, 0);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy",   {31'd0, bus.busy},  32'd0);
    chk("async_reset_valid",  {31'd0, bus.valid}, 32'd0);
    chk("async_reset_result", bus.result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_idle", {31'd0, bus.busy | bus.valid}, 32'd0);

    issue("divu_after_reset", 2'b01, 32'd100, 32'd7, 32'd14, 32, 1, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
